// File: rtl/fpu_result_if.sv
// Consumer-side handshake bundle for fpu_result_fifo: head entry plus valid/ready.
interface fpu_result_if #(
  parameter int DATA_W = 32,
  parameter int STAT_W = 4
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [STAT_W-1:0] out_status;
  logic [15:0]       out_ts;

  modport master (
    output out_valid, out_data, out_status, out_ts,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_status, out_ts,
    output out_ready
  );
endinterface

// File: rtl/fpu_result_fifo.sv
// Captures each new fpu result into a show-ahead FIFO drained over valid/ready.
// Optional per-entry timestamps are enabled with the macro FPU_RESULT_TS_EN.
module fpu_result_fifo #(
  parameter int DATA_W = 32,
  parameter int STAT_W = 4,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock100KHz,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [STAT_W-1:0] status_in,
  fpu_result_if.master      out_if,
  output logic [CNT_W-1:0]  count,
  output logic              drop,
  input  logic              drop_clr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] prev_data;
  logic [STAT_W-1:0] prev_status;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [STAT_W-1:0] stat_mem [DEPTH];

  logic new_result;
  logic full;
  logic pop;
  logic push_ok;
  logic discard;

  // A result is new when status rises from idle or the data/status word changes.
  assign new_result = (status_in != '0) &&
                      ((prev_status == '0) || (data_in != prev_data) ||
                       (status_in != prev_status));

  assign full    = (count == CNT_W'(DEPTH));
  assign pop     = out_if.out_valid && out_if.out_ready;
  assign push_ok = new_result && (!full || pop);
  assign discard = new_result && full && !pop;

  always_ff @(posedge clock100KHz) begin
    if (!reset) begin
      prev_data   <= '0;
      prev_status <= '0;
    end else begin
      prev_data   <= data_in;
      prev_status <= status_in;
    end
  end

  always_ff @(posedge clock100KHz) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Discard has priority over a simultaneous clear so no loss goes unreported.
  always_ff @(posedge clock100KHz) begin
    if (!reset)        drop <= 1'b0;
    else if (discard)  drop <= 1'b1;
    else if (drop_clr) drop <= 1'b0;
  end

  always_ff @(posedge clock100KHz) begin
    if (reset && push_ok) begin
      data_mem[wr_ptr] <= data_in;
      stat_mem[wr_ptr] <= status_in;
    end
  end

  assign out_if.out_valid  = (count != '0);
  assign out_if.out_data   = data_mem[rd_ptr];
  assign out_if.out_status = stat_mem[rd_ptr];

`ifdef FPU_RESULT_TS_EN
  logic [15:0] ts_cnt;
  logic [15:0] ts_mem [DEPTH];

  always_ff @(posedge clock100KHz) begin
    if (!reset) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 16'd1;
  end

  always_ff @(posedge clock100KHz) begin
    if (reset && push_ok) ts_mem[wr_ptr] <= ts_cnt;
  end

  assign out_if.out_ts = ts_mem[rd_ptr];
`else
  assign out_if.out_ts = 16'h0000;
`endif

endmodule

// File: tb/tb_fpu_result_fifo.sv
// Bench for fpu_result_fifo: directed scenarios plus random traffic against a queue model.
module tb_fpu_result_fifo;

  localparam int DATA_W = 32;
  localparam int STAT_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clock100KHz = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] data_in;
  logic [STAT_W-1:0] status_in;
  logic [CNT_W-1:0]  count;
  logic              drop;
  logic              drop_clr;

  fpu_result_if #(.DATA_W(DATA_W), .STAT_W(STAT_W)) bus ();

  fpu_result_fifo #(.DATA_W(DATA_W), .STAT_W(STAT_W), .DEPTH(DEPTH)) dut (
    .clock100KHz (clock100KHz),
    .reset       (reset),
    .data_in     (data_in),
    .status_in   (status_in),
    .out_if      (bus),
    .count       (count),
    .drop        (drop),
    .drop_clr    (drop_clr)
  );

  always #5 clock100KHz = ~clock100KHz;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [STAT_W-1:0] s;
    logic [15:0]       t;
  } ent_t;

  ent_t              mq[$];
  logic [DATA_W-1:0] m_pd;
  logic [STAT_W-1:0] m_ps;
  logic              m_drop;
  logic [15:0]       m_ts;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: one clock edge of the capture FIFO, expressed on a queue.
  task automatic model_edge(input logic rst_n, input logic [DATA_W-1:0] d,
                            input logic [STAT_W-1:0] s, input logic rdy, input logic clr);
    logic nr, full, pop, disc;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_pd = '0; m_ps = '0; m_drop = 1'b0; m_ts = '0;
      return;
    end
    nr   = (s != 0) && ((m_ps == 0) || (d != m_pd) || (s != m_ps));
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && rdy;
    disc = nr && full && !pop;
    if (pop) void'(mq.pop_front());
    if (nr && !disc) begin
      e.d = d; e.s = s; e.t = m_ts;
      mq.push_back(e);
    end
    if (disc)     m_drop = 1'b1;
    else if (clr) m_drop = 1'b0;
    m_pd = d; m_ps = s; m_ts = m_ts + 16'd1;
  endtask

  task automatic check_outputs();
    chk("out_valid", bus.out_valid, mq.size() != 0);
    chk("count", count, mq.size());
    chk("drop", drop, m_drop);
    if (mq.size() != 0) begin
      chk("out_data", bus.out_data, mq[0].d);
      chk("out_status", bus.out_status, mq[0].s);
`ifdef FPU_RESULT_TS_EN
      chk("out_ts", bus.out_ts, mq[0].t);
`else
      chk("out_ts", bus.out_ts, 16'h0000);
`endif
    end
  endtask

  // Called at a falling edge: drive, take the rising edge, then compare.
  task automatic cyc(input logic rst_n, input logic [DATA_W-1:0] d,
                     input logic [STAT_W-1:0] s, input logic rdy, input logic clr);
    reset = rst_n; data_in = d; status_in = s; bus.out_ready = rdy; drop_clr = clr;
    @(posedge clock100KHz);
    model_edge(rst_n, d, s, rdy, clr);
    @(negedge clock100KHz);
    check_outputs();
  endtask

  logic [DATA_W-1:0] rd;
  logic [STAT_W-1:0] rs;
  logic [DATA_W-1:0] seq_d [5];
  logic [15:0]       ts_first;

  initial begin
    reset = 1'b0; data_in = '0; status_in = '0; bus.out_ready = 1'b0; drop_clr = 1'b0;
    m_pd = '0; m_ps = '0; m_drop = 1'b0; m_ts = '0;
    seq_d[0] = 32'h15400000; seq_d[1] = 32'h15800000; seq_d[2] = 32'h15C00000;
    seq_d[3] = 32'h16000000; seq_d[4] = 32'h16400000;
    @(negedge clock100KHz);

    // Reset, then idle bus
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_drop", drop, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'hDEAD0000 + i, '0, 1'b0, 1'b0);
    chk("idle_count", count, 0);

    // Stable result held for 20 cycles is captured once
    cyc(1'b1, 32'h15000000, 4'h1, 1'b0, 1'b0);
    chk("hold_first_data", bus.out_data, 32'h15000000);
    chk("hold_first_stat", bus.out_status, 4'h1);
    for (int i = 0; i < 19; i++) cyc(1'b1, 32'h15000000, 4'h1, 1'b0, 1'b0);
    chk("hold_count", count, 1);
    cyc(1'b1, '0, '0, 1'b1, 1'b0);
    chk("hold_drained", count, 0);

    // Overfill with five distinct results
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 3; j++) cyc(1'b1, seq_d[i], 4'h2, 1'b0, 1'b0);
    chk("ovf_count", count, DEPTH);
    chk("ovf_drop", drop, 1'b1);
    chk("ovf_head", bus.out_data, 32'h15400000);
    cyc(1'b1, seq_d[4], 4'h2, 1'b0, 1'b1);
    chk("drop_clr", drop, 1'b0);

    // Full, push with simultaneous pop
    cyc(1'b1, 32'h17000000, 4'h3, 1'b1, 1'b0);
    chk("fullpp_count", count, DEPTH);
    chk("fullpp_drop", drop, 1'b0);
    chk("fullpp_head", bus.out_data, 32'h15800000);
    for (int i = 0; i < 5; i++) cyc(1'b1, '0, '0, 1'b1, 1'b0);
    chk("drain_empty", bus.out_valid, 1'b0);

    // Reset with entries queued
    for (int i = 0; i < 3; i++) cyc(1'b1, seq_d[i], 4'h5, 1'b0, 1'b0);
    chk("pre_rst_count", count, 3);
    cyc(1'b0, seq_d[3], 4'h5, 1'b1, 1'b0);
    chk("midrst_count", count, 0);
    chk("midrst_valid", bus.out_valid, 1'b0);
    cyc(1'b1, seq_d[3], 4'h5, 1'b0, 1'b0);
    chk("post_rst_capture", bus.out_data, seq_d[3]);
    cyc(1'b1, '0, '0, 1'b1, 1'b0);

    // Timestamps at counter values 10 and 25
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    while (m_ts != 16'd10) cyc(1'b1, '0, '0, 1'b0, 1'b0);
    cyc(1'b1, 32'h18000000, 4'h1, 1'b0, 1'b0);
    while (m_ts != 16'd25) cyc(1'b1, '0, '0, 1'b0, 1'b0);
    cyc(1'b1, 32'h18400000, 4'h1, 1'b0, 1'b0);
`ifdef FPU_RESULT_TS_EN
    ts_first = 16'd10;
`else
    ts_first = 16'd0;
`endif
    chk("ts_head", bus.out_ts, ts_first);
    cyc(1'b1, '0, '0, 1'b1, 1'b0);
    chk("ts_second", bus.out_ts, ts_first == 16'd0 ? 16'd0 : 16'd25);
    cyc(1'b1, '0, '0, 1'b1, 1'b0);

    // Random traffic with repeats, idles, back-pressure and rare resets
    rd = 32'h15000000; rs = 4'h1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        rd = 32'h15000000 + ($urandom_range(0, 3) << 20);
        rs = 4'($urandom_range(0, 3));
      end
      cyc($urandom_range(0, 199) != 0, rd, rs,
          $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_result_fifo.md
Name: fpu_result_fifo

Overview:
Downstream capture stage for the fpu. Watches the fpu result bus (data_out/status_out) and detects each new completed result. Pushes each {data, status} pair into a small FIFO. Presents entries to the consumer (display/UART/host logic) over a valid/ready handshake, so no fpu result is lost while the consumer is busy.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
DATA_W, 32, result data width (fpu float word: 1 sign, 6 exponent, 25 mantissa)
STAT_W, 4, fpu status width
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clock100KHz  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
data_in  in  DATA_W  fpu data_out
status_in  in  STAT_W  fpu status_out; 0 = no result / busy, nonzero = result present
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head entry
out_data  out  DATA_W  head entry data
out_status  out  STAT_W  head entry status
out_ts  out  16  head entry timestamp (see Optional Feature)
count  out  CNT_W  current occupancy, 0..DEPTH
drop  out  1  sticky: a result was lost because the FIFO was full
drop_clr  in  1  clears drop

Behaviour:
- Everything updates on rising clock100KHz only. Reset acts when reset==0 at a clock edge; no asynchronous path.
- Reset values: out_valid=0, count=0, drop=0, rd/wr pointers=0, prev_data=0, prev_status=0, timestamp counter=0. out_data/out_status/out_ts are don't-care while out_valid=0; memory contents are not reset.
- Capture detect: every cycle register prev_data<=data_in and prev_status<=status_in.
- new_result = (status_in!=0) && ((prev_status==0) || (data_in!=prev_data) || (status_in!=prev_status)).
- A result held stable for many cycles is captured exactly once. Identical results produce two captures only if separated by at least one cycle with status_in==0.
- Push: new_result in cycle N writes mem[wr_ptr] at the end of cycle N. The entry is visible at out_* with out_valid=1 from cycle N+1 if the FIFO was empty. Latency is 1 cycle.
- Pop: out_valid && out_ready at an edge advances rd_ptr. out_* show the next entry (show-ahead, read combinationally from registered memory) in the following cycle.
- out_valid = (count!=0). out_data/out_status/out_ts must stay stable while out_valid=1 and out_ready=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count tracks +1 on push only, -1 on pop only, and is unchanged when both occur.
- Full with a push and a pop in the same cycle: both succeed, count stays DEPTH, no drop.
- Full with a push and no pop: the entry is discarded, FIFO contents unchanged, drop<=1.
- Empty: a pop is impossible (out_valid=0); out_ready is ignored.
- drop: set by a discard, cleared by drop_clr=1. If a discard and drop_clr occur in the same cycle, set wins.
- Reset mid-operation: FIFO flushed, all pending entries lost, prev_* cleared. A result already present on status_in at reset release is therefore captured once on the first cycle after release.

Optional Feature:
Macro FPU_RESULT_TS_EN.
- Defined: a 16-bit free-running cycle counter (reset 0, wraps 0xFFFF->0) is stored with each entry at push time. out_ts shows the head entry's stored value.
- Not defined: no counter and no timestamp storage; out_ts is driven to 16'h0000. Port list is identical in both builds.

Test Plan:
1. Reset low 2 cycles, then high -> out_valid=0, count=0, drop=0; status_in=0 on all inputs for 10 cycles -> no push.
2. data_in=32'h15000000, status_in=4'h1 held for 20 cycles, out_ready=0 -> exactly one entry, count=1, out_data=32'h15000000, out_status=4'h1 from the cycle after first assertion.
3. Five distinct results (32'h15400000, status 4'h2, etc.), one every 3 cycles, out_ready=0 -> count=4, drop=1 after the 5th, head = first result; drop_clr pulse -> drop=0.
4. FIFO full, out_ready=1 in the same cycle as a new result -> count stays 4, drop stays 0, FIFO order preserved on drain.
5. Three entries queued, reset pulled low for one cycle with out_ready toggling -> count=0, out_valid=0 after the edge; the next result is captured normally.
6. With FPU_RESULT_TS_EN: results pushed at counter values 10 and 25 -> out_ts=10, then 25 after a pop. Without the macro -> out_ts=0 for all entries.
